trap_controller: RTL and testbench



---
 rtl/trap_controller.sv | 157 +++++++++++++++
 tb/tb_trap_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller
// Machine-mode trap sequencer between the CSR file and the MA stage.
// It synchronises the timer and external interrupt lines and qualifies them
// against mstatus.MIE and the mie enable bits. When MA retires an instruction
// safely, it runs a fixed sequence: one TRAP or RET cycle, then HOLD_CYCLES of
// HOLD, then back to IDLE.
//
// Ports
//   clk, reset_n                  rising-edge clock, synchronous active-low reset
//   t_interrupt, e_interrupt      asynchronous interrupt levels
//   mstatus_mie, mie_mtie/meie    enable bits from the CSR file
//   mtvec, mepc                   CSR values (trap vector, return address)
//   pc_ma, ma_valid, ma_stall     MA-stage PC, retire-valid and stall
//   is_mret                       MA instruction is MRET
//   trap_we, mret_we              one-cycle CSR commit strobes
//   mepc_wdata, mcause_wdata      values committed with trap_we
//   mip_mtip, mip_meip            synchronised interrupt lines for mip
//   flush, redirect_valid         pipeline kill and PC load
//   redirect_pc                   fetch target
//   busy                          sequencer is not IDLE
module trap_controller #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            t_interrupt,
  input  logic            e_interrupt,
  input  logic            mstatus_mie,
  input  logic            mie_mtie,
  input  logic            mie_meie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] pc_ma,
  input  logic            ma_valid,
  input  logic            ma_stall,
  input  logic            is_mret,
  output logic            trap_we,
  output logic            mret_we,
  output logic [XLEN-1:0] mepc_wdata,
  output logic [XLEN-1:0] mcause_wdata,
  output logic            mip_mtip,
  output logic            mip_meip,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRAP = 2'd1;
  localparam logic [1:0] ST_RET  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);

  logic [1:0]             state;
  logic [2:0]             hold_cnt;
  logic [SYNC_STAGES-1:0] t_sync;
  logic [SYNC_STAGES-1:0] e_sync;
  logic [XLEN-1:0]        target_q;

  logic            go;
  logic            pending;
  logic            sel_ext;
  logic [3:0]      code;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] cause;

  // Synchroniser chains. The last flop of each chain is the architectural
  // mip bit, so pending is always evaluated on the synchronised level.
  // NOTE: reset is sampled inside the clocked block only (synchronous); the
  // flop state updates use <= so every stage samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      t_sync <= '0;
      e_sync <= '0;
    end else begin
      t_sync[0] <= t_interrupt;
      e_sync[0] <= e_interrupt;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        t_sync[i] <= t_sync[i-1];
        e_sync[i] <= e_sync[i-1];
      end
    end
  end

  assign mip_mtip = t_sync[SYNC_STAGES-1];
  assign mip_meip = e_sync[SYNC_STAGES-1];

  // Cause selection and trap target; external beats timer.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    go      = ma_valid & ~ma_stall;
    sel_ext = mip_meip & mie_meie;
    pending = mstatus_mie & (sel_ext | (mip_mtip & mie_mtie));
    code    = sel_ext ? 4'd11 : 4'd7;
    cause   = {1'b1, {(XLEN-5){1'b0}}, code};
    base    = {mtvec[XLEN-1:2], 2'b00};
    vec_off = {{(XLEN-6){1'b0}}, code, 2'b00};
    // Vectored mode adds 4*code; the sum wraps modulo 2^XLEN.
    target  = (mtvec[1:0] == 2'b01) ? (base + vec_off) : base;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      mepc_wdata   <= '0;
      mcause_wdata <= '0;
      target_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // MRET wins over a same-cycle interrupt; the interrupt is
          // re-evaluated once HOLD has drained.
          if (go && is_mret) begin
            state <= ST_RET;
          end else if (go && pending) begin
            state        <= ST_TRAP;
            mepc_wdata   <= pc_ma + XLEN'(4);
            mcause_wdata <= cause;
            target_q     <= target;
          end
        end
        ST_TRAP, ST_RET: begin
          state    <= ST_HOLD;
          hold_cnt <= '0;
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the state register alone, so there is no
  // combinational path from any input to flush or redirect_valid.
  assign trap_we        = (state == ST_TRAP);
  assign mret_we        = (state == ST_RET);
  assign flush          = trap_we | mret_we;
  assign redirect_valid = flush;
  assign busy           = (state != ST_IDLE);
  assign redirect_pc    = trap_we ? target_q :
                          mret_we ? mepc     : '0;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  localparam int XLEN = 32;
  localparam int SYNC = 2;
  localparam int HOLD = 2;

  logic            clk;
  logic            reset_n;
  logic            t_interrupt;
  logic            e_interrupt;
  logic            mstatus_mie;
  logic            mie_mtie;
  logic            mie_meie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] pc_ma;
  logic            ma_valid;
  logic            ma_stall;
  logic            is_mret;
  logic            trap_we;
  logic            mret_we;
  logic [XLEN-1:0] mepc_wdata;
  logic [XLEN-1:0] mcause_wdata;
  logic            mip_mtip;
  logic            mip_meip;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  trap_controller #(
    .XLEN        (XLEN),
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .t_interrupt    (t_interrupt),
    .e_interrupt    (e_interrupt),
    .mstatus_mie    (mstatus_mie),
    .mie_mtie       (mie_mtie),
    .mie_meie       (mie_meie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .pc_ma          (pc_ma),
    .ma_valid       (ma_valid),
    .ma_stall       (ma_stall),
    .is_mret        (is_mret),
    .trap_we        (trap_we),
    .mret_we        (mret_we),
    .mepc_wdata     (mepc_wdata),
    .mcause_wdata   (mcause_wdata),
    .mip_mtip       (mip_mtip),
    .mip_meip       (mip_meip),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_trap;
    logic [31:0] pc;
    logic [31:0] mepc_w;
    logic [31:0] cause_w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   lat2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_trap, input logic [31:0] pc,
                      input logic [31:0] mw, input logic [31:0] cw);
    exp_t e;
    e.is_trap = is_trap;
    e.pc      = pc;
    e.mepc_w  = mw;
    e.cause_w = cw;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next flush cycle, then pops the oldest expected
  // event and compares every redirect/commit output against it.
  task automatic wait_event(input string tag, input int budget, output int n);
    logic found;
    exp_t e;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      n++;
      if (flush) found = 1'b1;
    end
    check({tag, ".seen"}, {31'd0, found}, 32'd1);
    if (found && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".trap_we"}, {31'd0, trap_we}, {31'd0, e.is_trap});
      check({tag, ".mret_we"}, {31'd0, mret_we}, {31'd0, ~e.is_trap});
      check({tag, ".rv"},      {31'd0, redirect_valid}, 32'd1);
      check({tag, ".busy"},    {31'd0, busy}, 32'd1);
      check({tag, ".pc"},      redirect_pc, e.pc);
      check({tag, ".mepc_w"},  mepc_wdata, e.mepc_w);
      check({tag, ".cause_w"}, mcause_wdata, e.cause_w);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".strobes"}, {28'd0, trap_we, mret_we, flush, redirect_valid}, 32'd0);
    check({tag, ".busy"},    {31'd0, busy}, 32'd0);
    check({tag, ".mip"},     {30'd0, mip_mtip, mip_meip}, 32'd0);
    check({tag, ".pc"},      redirect_pc, 32'd0);
    check({tag, ".mepc_w"},  mepc_wdata, 32'd0);
    check({tag, ".cause_w"}, mcause_wdata, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; t_interrupt = 1'b0; e_interrupt = 1'b0;
    mstatus_mie = 1'b0; mie_mtie = 1'b0; mie_meie = 1'b0;
    mtvec = '0; mepc = '0; pc_ma = '0;
    ma_valid = 1'b0; ma_stall = 1'b0; is_mret = 1'b0;

    // Reset state
    idle_cycles(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle_cycles(2);

    // Vectored external trap, latency SYNC+1, then HOLD busy cycles
    mtvec = 32'h0000_1001; mstatus_mie = 1'b1; mie_meie = 1'b1;
    pc_ma = 32'h200; ma_valid = 1'b1; e_interrupt = 1'b1;
    push(1'b1, 32'h0000_102C, 32'h204, 32'h8000_000B);
    wait_event("vec_ext", 10, lat);
    check("vec_ext.latency", lat, SYNC + 1);
    e_interrupt = 1'b0; ma_valid = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      check("hold.busy",  {31'd0, busy}, 32'd1);
      check("hold.flush", {31'd0, flush}, 32'd0);
    end
    @(negedge clk);
    check("hold.done", {31'd0, busy}, 32'd0);
    check("hold.keep_mepc", mepc_wdata, 32'h204);
    idle_cycles(3);

    // Priority (external over timer), direct mode, then timer trap
    mtvec = 32'h0000_1000; mie_mtie = 1'b1; pc_ma = 32'h400;
    t_interrupt = 1'b1; e_interrupt = 1'b1; ma_valid = 1'b1;
    push(1'b1, 32'h0000_1000, 32'h404, 32'h8000_000B);
    wait_event("prio_ext", 10, lat);
    e_interrupt = 1'b0;
    push(1'b1, 32'h0000_1000, 32'h404, 32'h8000_0007);
    wait_event("timer", 10, lat);
    check("redirect_spacing", lat, 1 + HOLD + 1);
    t_interrupt = 1'b0; ma_valid = 1'b0; mie_mtie = 1'b0;
    idle_cycles(6);

    // Gating: MIE off, stalled, not valid -> no trap for 5 cycles each
    mtvec = 32'h0000_1001; pc_ma = 32'h600; e_interrupt = 1'b1;
    mstatus_mie = 1'b0; ma_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gate_mie.trap_we", {31'd0, trap_we}, 32'd0);
    end
    mstatus_mie = 1'b1; ma_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gate_stall.trap_we", {31'd0, trap_we}, 32'd0);
    end
    ma_stall = 1'b0; ma_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gate_valid.trap_we", {31'd0, trap_we}, 32'd0);
    end
    ma_valid = 1'b1;
    push(1'b1, 32'h0000_102C, 32'h604, 32'h8000_000B);
    wait_event("gate_go", 10, lat);
    check("gate_go.latency", lat, 1);
    e_interrupt = 1'b0; ma_valid = 1'b0;
    idle_cycles(6);

    // MRET with a same-cycle pending interrupt: MRET first, trap after HOLD
    e_interrupt = 1'b1;
    idle_cycles(4);
    mepc = 32'h0000_0300; is_mret = 1'b1; ma_valid = 1'b1;
    // mepc_wdata/mcause_wdata keep the previous trap's values through MRET
    push(1'b0, 32'h0000_0300, 32'h604, 32'h8000_000B);
    wait_event("mret", 10, lat);
    check("mret.latency", lat, 1);
    is_mret = 1'b0; pc_ma = 32'h700;
    push(1'b1, 32'h0000_102C, 32'h704, 32'h8000_000B);
    wait_event("mret_then_trap", 10, lat);
    check("mret_then_trap.spacing", lat, 1 + HOLD + 1);
    e_interrupt = 1'b0; ma_valid = 1'b0;
    idle_cycles(6);

    // Vectored target wraps modulo 2^32
    mtvec = 32'hFFFF_FFF1; pc_ma = 32'h800; e_interrupt = 1'b1; ma_valid = 1'b1;
    push(1'b1, 32'h0000_001C, 32'h804, 32'h8000_000B);
    wait_event("wrap", 10, lat);
    e_interrupt = 1'b0; ma_valid = 1'b0;
    idle_cycles(6);

    // Reset during the TRAP cycle, then re-take after full sync latency
    mtvec = 32'h0000_1001; pc_ma = 32'h900; e_interrupt = 1'b1; ma_valid = 1'b1;
    push(1'b1, 32'h0000_102C, 32'h904, 32'h8000_000B);
    wait_event("pre_reset", 10, lat);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_trap");
    reset_n = 1'b1;
    push(1'b1, 32'h0000_102C, 32'h904, 32'h8000_000B);
    wait_event("retake", 10, lat2);
    check("retake.latency", lat2, SYNC + 1);

    // Reset in mid-HOLD
    @(negedge clk);
    check("mid_hold.busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0; e_interrupt = 1'b0; ma_valid = 1'b0;
    @(negedge clk);
    check_all_zero("reset_hold");
    reset_n = 1'b1;
    idle_cycles(4);
    check("final.busy", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
